// File: rtl/min_search_ctrl.sv
// Sequential min/argmin search over a block of unsigned samples in a
// synchronous-read memory: one read per cycle, one shared less-than comparator.

module comparator_less_than #(
  parameter int WIDTH = 13
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             lt_o
);
  assign lt_o = (a_i < b_i);
endmodule

module min_search_ctrl #(
  parameter int DATA_WIDTH = 13,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] min_o,
  output logic [ADDR_WIDTH-1:0] min_idx_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   len_sat;
  logic                  rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_d;
  logic                  busy_d;
  logic                  done_d;
  logic [DATA_WIDTH-1:0] min_d;
  logic [ADDR_WIDTH-1:0] idx_d;

  // Read handshake: rd_en_o/rd_addr_o in cycle N returns rd_data_i in cycle
  // N+1 with no back-pressure; vld_q/idx_q mark that return cycle.
  logic                  vld_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [DATA_WIDTH-1:0] run_min;
  logic [ADDR_WIDTH-1:0] run_idx;
  logic                  lt;
  logic                  take;
  logic [DATA_WIDTH-1:0] cand_min;
  logic [ADDR_WIDTH-1:0] cand_idx;

  assign state_o = state_q;
  assign len_sat = (len_i > MAX_LEN) ? MAX_LEN : len_i;

  comparator_less_than #(.WIDTH(DATA_WIDTH)) u_cmp (
    .a_i  (rd_data_i),
    .b_i  (run_min),
    .lt_o (lt)
  );

  // Index 0 seeds the running minimum; strict less-than keeps the earliest tie.
  assign take     = vld_q && ((idx_q == '0) || lt);
  assign cand_min = take ? rd_data_i : run_min;
  assign cand_idx = take ? idx_q : run_idx;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_o;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    min_d     = min_o;
    idx_d     = min_idx_o;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_sat == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            min_d   = '1;
            idx_d   = '0;
          end else begin
            state_d   = SCAN;
            len_d     = len_sat;
            cnt_d     = {{ADDR_WIDTH{1'b0}}, 1'b1};
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
            busy_d    = 1'b1;
          end
        end
      end
      SCAN: begin
        busy_d = 1'b1;
        // cnt_q is the next address to read; reaching len_q means all issued.
        if (cnt_q == len_q) begin
          state_d = DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = cnt_q[ADDR_WIDTH-1:0];
          cnt_d     = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
        min_d   = cand_min;
        idx_d   = cand_idx;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      rd_en_o   <= 1'b0;
      rd_addr_o <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      min_o     <= '0;
      min_idx_o <= '0;
      vld_q     <= 1'b0;
      idx_q     <= '0;
      run_min   <= '0;
      run_idx   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      rd_en_o   <= rd_en_d;
      rd_addr_o <= rd_addr_d;
      busy_o    <= busy_d;
      done_o    <= done_d;
      min_o     <= min_d;
      min_idx_o <= idx_d;
      vld_q     <= rd_en_o;
      idx_q     <= rd_addr_o;
      run_min   <= cand_min;
      run_idx   <= cand_idx;
    end
  end

endmodule

// File: tb/tb_min_search_ctrl.sv
// Directed bench for min_search_ctrl: sample memory model, per-run latency,
// read-sequence and result checks, start-ignore and abort scenarios.

module tb_min_search_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [8:0]  len_i;
  logic        rd_en_o;
  logic [7:0]  rd_addr_o;
  logic [12:0] rd_data_i;
  logic        busy_o;
  logic        done_o;
  logic [12:0] min_o;
  logic [7:0]  min_idx_o;
  logic [1:0]  state_o;

  logic [12:0] mem [256];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [12:0] prev_min = '0;
  logic [7:0]  prev_idx = '0;

  always #5 clk = ~clk;

  min_search_ctrl #(.DATA_WIDTH(13), .ADDR_WIDTH(8)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .len_i     (len_i),
    .rd_en_o   (rd_en_o),
    .rd_addr_o (rd_addr_o),
    .rd_data_i (rd_data_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .min_o     (min_o),
    .min_idx_o (min_idx_o),
    .state_o   (state_o)
  );

  // Synchronous-read sample buffer.
  always @(posedge clk) begin
    if (rd_en_o) rd_data_i <= mem[rd_addr_o];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  // Starts a search at the next falling edge (cycle T) and follows it to done_o.
  task automatic run_search(input string name, input int len, input logic [12:0] exp_min,
                            input logic [7:0] exp_idx, input int pulse_at);
    int lsat;
    int reads;
    int addr_err;
    int busy_cnt;
    int done_cyc;
    logic [12:0] got_min;
    logic [7:0]  got_idx;
    lsat     = (len > 256) ? 256 : len;
    reads    = 0;
    addr_err = 0;
    busy_cnt = 0;
    done_cyc = 0;
    got_min  = '0;
    got_idx  = '0;
    @(negedge clk);
    start_i = 1'b1;
    len_i   = 9'(len);
    for (int c = 1; c <= 400 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (c == pulse_at) begin
        start_i = 1'b1;
        len_i   = 9'd3;
      end else begin
        start_i = 1'b0;
      end
      if (c == 1 && lsat != 0) begin
        check_eq({name, "_min_hold"}, 32'(min_o), 32'(prev_min));
        check_eq({name, "_idx_hold"}, 32'(min_idx_o), 32'(prev_idx));
      end
      if (rd_en_o) begin
        if (rd_addr_o != 8'(reads)) addr_err++;
        reads++;
      end
      if (busy_o) busy_cnt++;
      if (done_o) begin
        done_cyc = c;
        got_min  = min_o;
        got_idx  = min_idx_o;
      end
    end
    start_i = 1'b0;
    check_eq({name, "_reads"}, 32'(reads), 32'(lsat));
    check_eq({name, "_addr_seq"}, 32'(addr_err), 32'd0);
    check_eq({name, "_busy_cycles"}, 32'(busy_cnt), (lsat == 0) ? 32'd0 : 32'(lsat + 1));
    check_eq({name, "_done_cycle"}, 32'(done_cyc), (lsat == 0) ? 32'd1 : 32'(lsat + 2));
    check_eq({name, "_min"}, 32'(got_min), 32'(exp_min));
    check_eq({name, "_idx"}, 32'(got_idx), 32'(exp_idx));
    prev_min = exp_min;
    prev_idx = exp_idx;
  endtask

  initial begin
    int late_done;
    rst_i   = 1'b1;
    start_i = 1'b0;
    len_i   = '0;
    clear_mem();
    repeat (3) @(negedge clk);
    check_eq("rst_rd_en", 32'(rd_en_o), 32'd0);
    check_eq("rst_rd_addr", 32'(rd_addr_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_min", 32'(min_o), 32'd0);
    check_eq("rst_idx", 32'(min_idx_o), 32'd0);
    check_eq("rst_state", 32'(state_o), 32'd0);
    rst_i = 1'b0;

    // Tie at value 3 keeps index 1.
    mem[0] = 13'd7; mem[1] = 13'd3; mem[2] = 13'd9; mem[3] = 13'd3; mem[4] = 13'd12;
    run_search("tie5", 5, 13'd3, 8'd1, 0);

    // Zero length: no reads, all-ones minimum.
    run_search("len0", 0, 13'h1FFF, 8'd0, 0);

    mem[0] = 13'h1FFF;
    run_search("len1", 1, 13'h1FFF, 8'd0, 0);

    // Strictly decreasing: every sample replaces the minimum.
    for (int i = 0; i < 100; i++) mem[i] = 13'(100 - i);
    run_search("dec100", 100, 13'd1, 8'd99, 0);

    // Full-size block with the minimum at the last address, then saturated length.
    for (int i = 0; i < 256; i++) mem[i] = 13'(500 + i);
    mem[255] = 13'd5;
    run_search("len256", 256, 13'd5, 8'd255, 0);
    run_search("len300", 300, 13'd5, 8'd255, 0);

    // Start pulsed mid-scan is ignored; a start in the cycle after done is taken.
    clear_mem();
    mem[0] = 13'd7; mem[1] = 13'd3; mem[2] = 13'd9; mem[3] = 13'd3; mem[4] = 13'd12;
    run_search("ign_start", 5, 13'd3, 8'd1, 2);
    mem[0] = 13'd40; mem[1] = 13'd50; mem[2] = 13'd20;
    run_search("b2b", 3, 13'd20, 8'd2, 0);

    // Abort mid-scan.
    @(negedge clk);
    start_i = 1'b1;
    len_i   = 9'd5;
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check_eq("abort_rd_en", 32'(rd_en_o), 32'd0);
    check_eq("abort_rd_addr", 32'(rd_addr_o), 32'd0);
    check_eq("abort_busy", 32'(busy_o), 32'd0);
    check_eq("abort_min", 32'(min_o), 32'd0);
    check_eq("abort_idx", 32'(min_idx_o), 32'd0);
    check_eq("abort_state", 32'(state_o), 32'd0);
    late_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_o || busy_o) late_done++;
    end
    check_eq("abort_no_done", 32'(late_done), 32'd0);
    prev_min = '0;
    prev_idx = '0;

    mem[0] = 13'd5; mem[1] = 13'd2; mem[2] = 13'd8;
    run_search("post_abort", 3, 13'd2, 8'd1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/min_search_ctrl.md
# min_search_ctrl

Sequential minimum/argmin search controller. It scans a block of unsigned samples held in an external synchronous-read memory, one address per cycle, and routes each returned sample through a single `comparatorLessThan` instance against the running minimum. It reports the smallest value and the index of its first occurrence. The block sits between the sample buffer and downstream control logic that needs the block minimum, such as peak/floor detection or normalisation.

## Interface
- `DATA_WIDTH`, 13, sample width in bits; unsigned.
- `ADDR_WIDTH`, 8, memory address width; the maximum block length is 2^ADDR_WIDTH.

- `clk_i`, input, 1, single clock; all logic is on its rising edge.
- `rst_i`, input, 1, synchronous, active-high reset.
- `start_i`, input, 1, begins a search. Sampled only in IDLE; ignored in every other state.
- `len_i`, input, ADDR_WIDTH+1, number of samples to scan. Latched at start. Values above 2^ADDR_WIDTH saturate to 2^ADDR_WIDTH.
- `rd_en_o`, output, 1, memory read strobe.
- `rd_addr_o`, output, ADDR_WIDTH, memory read address.
- `rd_data_i`, input, DATA_WIDTH, memory read data. Valid exactly one cycle after the matching `rd_en_o`/`rd_addr_o`.
- `busy_o`, output, 1, high while a search is in progress (SCAN, DRAIN).
- `done_o`, output, 1, one-cycle pulse; the results are valid in that cycle.
- `min_o`, output, DATA_WIDTH, minimum value of the last completed search.
- `min_idx_o`, output, ADDR_WIDTH, index of the first occurrence of `min_o`.

## Operation
- The FSM has four states:
  - IDLE: accepting `start_i`.
  - SCAN: issuing reads.
  - DRAIN: the last sample is in flight.
  - DONE: one cycle; `done_o` is high.
- Transitions:
  - IDLE -> SCAN on `start_i` with saturated length L ≥ 1. Latch L; set the address counter to 0.
  - IDLE -> DONE on `start_i` with L = 0. No reads are issued; `min_o` = all ones; `min_idx_o` = 0.
  - SCAN -> DRAIN after the read of address L-1 is issued.
  - DRAIN -> DONE after the last sample is compared.
  - DONE -> IDLE unconditionally.
- SCAN behaviour: `rd_en_o` = 1 and `rd_addr_o` = counter; the counter increments each cycle. The counter is ADDR_WIDTH+1 bits internally so that L = 2^ADDR_WIDTH terminates correctly; `rd_addr_o` is its low bits.
- Read pipeline: a 1-cycle valid flag plus a delayed index track each read.
  - The first returned sample (index 0) unconditionally initialises the running minimum and its index.
  - Each later sample with (`rd_data_i` < running min), as reported by the comparator, replaces the min and index.
- Ties keep the earlier index, because the comparison is strict less-than.
- Result update: `min_o` and `min_idx_o` update only on entry to DONE. They hold their values through IDLE, the next SCAN and DRAIN, until the next DONE.
- Reset: `rst_i` from any state returns to IDLE next edge. It clears all outputs to 0 and the internal state. No `done_o` is produced for an aborted search.

## Timing
- Reset values: `rd_en_o` = 0, `rd_addr_o` = 0, `busy_o` = 0, `done_o` = 0, `min_o` = 0, `min_idx_o` = 0.
- Let `start_i` be sampled at the end of cycle T, with L ≥ 1:
  - Cycles T+1 .. T+L: SCAN, with `rd_addr_o` = 0 .. L-1.
  - Cycle T+L+1: DRAIN; the last sample is compared.
  - Cycle T+L+2: `done_o` = 1 and results are valid.
  - Cycle T+L+3 onward: IDLE.
- `busy_o` is high in cycles T+1 .. T+L+1.
- Latency from `start_i` to `done_o` is L+2 cycles. There is no back-to-back overlap; the earliest next start is sampled in cycle T+L+3.
- For L = 0: `done_o` is high in T+1, and `busy_o` never asserts.
- `done_o`, `busy_o`, `rd_en_o`, `rd_addr_o`, `min_o` and `min_idx_o` are all registered outputs.

## Test plan
- Memory [7, 3, 9, 3, 12], len 5 -> reads at addresses 0..4 in T+1..T+5; `done_o` at T+7; `min_o` = 3; `min_idx_o` = 1 (tie keeps the earlier index).
- Strictly decreasing data 100, 99, …, 1 (len 100) -> `min_o` = 1, `min_idx_o` = 99. Verify the running minimum updates on every sample.
- len 0 -> no `rd_en_o`; `done_o` at T+1; `min_o` = 0x1FFF, `min_idx_o` = 0. len 1 with mem[0] = 0x1FFF -> `min_o` = 0x1FFF, idx 0, `done_o` at T+3.
- len 256 and len 300 (ADDR_WIDTH = 8), min placed at address 255 -> both runs issue exactly 256 reads; `rd_addr_o` wraps 255 -> no further reads; `min_idx_o` = 255; `done_o` at T+258.
- `start_i` pulsed during SCAN with different data/len -> ignored; the original search completes with correct results. A new start one cycle after `done_o` is accepted.
- `rst_i` asserted mid-SCAN -> next cycle all outputs are 0, IDLE, no `done_o`. A subsequent search of [5, 2, 8] returns min 2, idx 1.
